// File: rtl/partial_led_pkg.sv
// partial_led_pkg: register map, response codes and channel FSM states shared by the LED slave
package partial_led_pkg;
    localparam logic [1:0] REG_LED_DATA     = 2'd0;
    localparam logic [1:0] REG_CTRL         = 2'd1;
    localparam logic [1:0] REG_BLINK_PERIOD = 2'd2;
    localparam logic [1:0] REG_SCRATCH      = 2'd3;
    localparam int CTRL_BLINK_EN_BIT = 0;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/partial_led_axi_slave_if.sv
// partial_led_axi_slave_if: AXI4-Lite bus between the VIP master and the LED slave
interface partial_led_axi_slave_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0] awprot;
    logic awvalid;
    logic awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic wvalid;
    logic wready;
    logic [1:0] bresp;
    logic bvalid;
    logic bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0] arprot;
    logic arvalid;
    logic arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0] rresp;
    logic rvalid;
    logic rready;
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/partial_led_blinker.sv
// partial_led_blinker: registered LED drive, optionally gated by a square wave of blink_period cycles per half
module partial_led_blinker #(
    parameter int LED_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic [LED_WIDTH-1:0] led_data,
    input  logic blink_en,
    input  logic [31:0] blink_period,
    input  logic restart,
    output logic [LED_WIDTH-1:0] leds
);
    logic [31:0] count;
    logic phase;
    logic active;
    logic wrap;
    assign active = blink_en && blink_period != '0;
    assign wrap = count == blink_period - 32'd1;
    // Idle or restarted blinker parks in the lit phase so enabling always starts with LEDs on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            phase <= 1'b0;
            leds <= '0;
        end else begin
            count <= (restart || !active || wrap) ? '0 : count + 32'd1;
            phase <= (restart || !active) ? 1'b1 : wrap ? ~phase : phase;
            leds <= (!active || phase) ? led_data : '0;
        end
    end
endmodule

// File: rtl/partial_led_axi_slave.sv
// partial_led_axi_slave: AXI4-Lite four-register file driving board LEDs with optional blink
module partial_led_axi_slave
    import partial_led_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int LED_WIDTH = 4
) (
    input  logic s00_axi_aclk,
    input  logic s00_axi_areset,
    partial_led_axi_slave_if.slave s00_axi,
    output logic [LED_WIDTH-1:0] leds
);
    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [1:0] w_idx;
    logic [1:0] r_idx;
    logic w_fire;
    logic r_fire;
    logic restart;
    logic unused_ok;
    assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};
    assign w_idx = s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign r_idx = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign restart = w_fire && (w_idx == REG_CTRL || w_idx == REG_BLINK_PERIOD);
    // Ready strobes are combinational, so they are masked while reset holds the FSMs idle
    always_comb begin
        w_fire = !s00_axi_areset && w_state == W_IDLE && s00_axi.awvalid && s00_axi.wvalid;
        w_next = w_fire ? W_RESP : (w_state == W_RESP && s00_axi.bready) ? W_IDLE : w_state;
        s00_axi.awready = w_fire;
        s00_axi.wready = w_fire;
        s00_axi.bvalid = w_state == W_RESP;
        s00_axi.bresp = RESP_OKAY;
    end
    always_comb begin
        r_fire = !s00_axi_areset && r_state == R_IDLE && s00_axi.arvalid;
        r_next = r_fire ? R_DATA : (r_state == R_DATA && s00_axi.rready) ? R_IDLE : r_state;
        s00_axi.arready = r_fire;
        s00_axi.rvalid = r_state == R_DATA;
        s00_axi.rresp = RESP_OKAY;
    end
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            s00_axi.rdata <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            if (r_fire) s00_axi.rdata <= regs[r_idx];
            if (w_fire)
                for (int b = 0; b < C_S_AXI_DATA_WIDTH / 8; b++)
                    if (s00_axi.wstrb[b]) regs[w_idx][8*b +: 8] <= s00_axi.wdata[8*b +: 8];
        end
    end
    partial_led_blinker #(.LED_WIDTH(LED_WIDTH)) u_blinker (
        .clk(s00_axi_aclk),
        .rst(s00_axi_areset),
        .led_data(regs[REG_LED_DATA][LED_WIDTH-1:0]),
        .blink_en(regs[REG_CTRL][CTRL_BLINK_EN_BIT]),
        .blink_period(regs[REG_BLINK_PERIOD]),
        .restart(restart),
        .leds(leds)
    );
endmodule

// File: doc/partial_led_axi_slave.md
Name: partial_led_axi_slave

Overview:
AXI4-Lite slave register file plus LED driver. It sits directly downstream of the AXI VIP master in the partial_led block design.
- Four 32-bit read/write registers.
- Drives the board LED pins from those registers, with an optional blink mode.
- Write-then-read-back of any value returns that value, so the existing sequential write/read example test passes unchanged.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, AXI byte-address width; four word registers.
- LED_WIDTH, 4, number of LED outputs; must be 1..32.

Ports:
- s00_axi_aclk  in  1  single clock
- s00_axi_areset  in  1  asynchronous, active-high reset
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid  in  1  write-address valid
- s00_axi_awready  out  1  write-address ready
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte strobes
- s00_axi_wvalid  in  1  write-data valid
- s00_axi_wready  out  1  write-data ready
- s00_axi_bresp  out  2  write response, always 2'b00 (OKAY)
- s00_axi_bvalid  out  1  write-response valid
- s00_axi_bready  in  1  write-response ready
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid  in  1  read-address valid
- s00_axi_arready  out  1  read-address ready
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  read response, always 2'b00
- s00_axi_rvalid  out  1  read-data valid
- s00_axi_rready  in  1  read-data ready
- leds  out  LED_WIDTH  LED drive

Behaviour:
Reset:
- All registers, all ready/valid outputs, rdata, blink counter, phase and leds go to 0.
- Reset is asynchronous: it aborts any in-flight transaction immediately, with no response issued.

Register map (word index = addr[3:2]; addr[1:0] ignored):
- 0x0 LED_DATA
- 0x4 CTRL: bit0 BLINK_EN
- 0x8 BLINK_PERIOD: cycles per half-period
- 0xC SCRATCH
- All four are full 32-bit R/W.

Write channel, FSM W_IDLE -> W_RESP:
- W_IDLE: when awvalid && wvalid, pulse awready and wready together for exactly one cycle.
- Register update in that cycle: byte i is updated iff wstrb[i]. A zero strobe writes nothing but still completes the handshake.
- Next cycle: bvalid=1, FSM enters W_RESP.
- W_RESP: hold bvalid until bready, then return to W_IDLE.
- awready/wready are never asserted while bvalid=1.
- awvalid without wvalid, or the reverse: wait; no partial acceptance.

Read channel, FSM R_IDLE -> R_DATA, independent of the write channel:
- R_IDLE: when arvalid, pulse arready for one cycle and capture rdata = reg[araddr[3:2]] in that cycle.
- Next cycle: rvalid=1.
- R_DATA: hold rvalid and rdata stable until rready, then return to R_IDLE.
- arready is never asserted while rvalid=1.
- Read and write handshakes in the same cycle to the same register: the read returns the pre-write value.

LED path:
- BLINK_EN=0: leds = LED_DATA[LED_WIDTH-1:0], registered, 1-cycle latency after the write handshake. counter=0, phase=1.
- BLINK_EN=1 and BLINK_PERIOD=0: blinking is disabled; leds = LED_DATA.
- BLINK_EN=1 and BLINK_PERIOD>=1:
  - The 32-bit counter increments each cycle.
  - When counter == BLINK_PERIOD-1: counter wraps to 0 and phase toggles.
  - leds = phase ? LED_DATA : 0.
  - Phase starts at 1 when blink is enabled.
- A write to BLINK_PERIOD or CTRL resets counter to 0 and phase to 1 on the following cycle.
- A BLINK_PERIOD write below the current count therefore cannot skip the wrap.

Decomposition:
- Package partial_led_pkg holds:
  - register index constants REG_LED_DATA=0, REG_CTRL=1, REG_BLINK_PERIOD=2, REG_SCRATCH=3
  - CTRL_BLINK_EN_BIT=0
  - RESP_OKAY=2'b00
  - the enums for the write and read channel FSM states
- One sub-module, partial_led_blinker: inputs LED_DATA, BLINK_EN, BLINK_PERIOD and a restart pulse; output leds.
- The AXI register file stays in the top module.

Test Plan:
- Reset, then write 0x1,0x2,0x3,0x4 to 0x0/0x4/0x8/0xC and read back -> OKAY responses, reads return 1,2,3,4. After BLINK_EN=1 with period 3, leds toggle 1 <-> 0 every 3 cycles.
- BLINK_EN=0, write LED_DATA=0xA with wstrb=4'b0001 -> leds=4'hA one cycle after the handshake. Then write 0xFFFFFFFF with wstrb=4'b0010 -> readback 0x0000FF0A.
- Present awvalid alone for 5 cycles, then wvalid -> awready/wready stay 0 until both are valid, then pulse together once. Hold bready=0 for 4 cycles -> bvalid stays high, with no new acceptance.
- Write BLINK_PERIOD=4, CTRL=1, LED_DATA=0xF -> leds: 0xF for 4 cycles, 0x0 for 4 cycles, repeating. Rewrite period to 0 -> leds fixed at 0xF.
- Same-cycle write SCRATCH=0x55 and read SCRATCH (old value 0x11) -> rdata=0x11; a later read returns 0x55. rready low for 3 cycles -> rdata stable.
- Assert s00_axi_areset while bvalid=1 and blink is active -> all outputs 0 asynchronously. After release, readback of every register returns 0.
